// File: rtl/mem_resp_pkg.sv
// Shared types for the tagged memory protocol: commands, tags, block addresses and block data.
// Tag 0 is reserved to mean "no tag", so tags cycle through 1..NTAG.
package mem_resp_pkg;

  localparam int XLEN        = 32;
  localparam int MEM_TAG_LEN = 4;
  localparam int MEM_IDX_LEN = 29;

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [1:0] {
    MEM_CMD_NONE  = 2'd0,
    MEM_CMD_LOAD  = 2'd1,
    MEM_CMD_STORE = 2'd2
  } mem_cmd_t;

  typedef logic [MEM_TAG_LEN-1:0] mem_tag_t;
  typedef logic [MEM_IDX_LEN-1:0] mem_idx_t;
  typedef xlen_t [1:0]            mem_blk_t;

  function automatic mem_tag_t tag_next(input mem_tag_t t, input int ntag);
    return (int'(t) >= ntag) ? mem_tag_t'(1) : t + mem_tag_t'(1);
  endfunction

endpackage

// File: rtl/mem_pend_fifo.sv
// Circular FIFO of outstanding queries {tag, idx, due}; head is visible combinationally.
// Push and pop may happen in the same cycle; the caller never pushes when full.
module mem_pend_fifo
  import mem_resp_pkg::*;
#(
  parameter int NTAG  = 15,
  parameter int IW    = 6,
  parameter int DUE_W = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  mem_tag_t                  push_tag,
  input  logic [IW-1:0]             push_idx,
  input  logic [DUE_W-1:0]          push_due,
  input  logic                      pop,
  output mem_tag_t                  head_tag,
  output logic [IW-1:0]             head_idx,
  output logic [DUE_W-1:0]          head_due,
  output logic                      empty,
  output logic [$clog2(NTAG+1)-1:0] count
);

  localparam int PW = (NTAG > 1) ? $clog2(NTAG) : 1;

  typedef struct packed {
    mem_tag_t         tag;
    logic [IW-1:0]    idx;
    logic [DUE_W-1:0] due;
  } pend_t;

  pend_t         ent_q [NTAG];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == NTAG - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      count <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) ent_q[wr_q] <= '{tag: push_tag, idx: push_idx, due: push_due};
  end

  assign head_tag = ent_q[rd_q].tag;
  assign head_idx = ent_q[rd_q].idx;
  assign head_due = ent_q[rd_q].due;
  assign empty    = (count == '0);

endmodule

// File: rtl/mem_resp.sv
// Tagged memory responder: one query accepted per cycle, answered exactly LATENCY cycles later.
// Queries are rejected (ack=0) while NTAG are outstanding; evicts are always absorbed.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 4,
  parameter int NTAG    = 15
) (
  input  logic     clock,
  input  logic     reset,
  input  mem_cmd_t qry_cmd,
  input  mem_idx_t qry_idx,
  input  mem_blk_t qry_blk,
  output mem_tag_t ack,
  output mem_tag_t ans_tag,
  output mem_blk_t ans_blk,
  input  logic     evict_valid,
  input  mem_idx_t evict_idx,
  input  mem_blk_t evict_blk
);

  localparam int AW    = $clog2(DEPTH);
  localparam int DUE_W = $clog2(LATENCY) + 2;
  localparam int CW    = $clog2(NTAG + 1);

  typedef logic [DUE_W-1:0] due_t;

  mem_blk_t      arr_q [DEPTH];
  mem_tag_t      next_tag_q;
  due_t          now_q;
  logic          accept;
  logic          is_store;
  logic          ans_busy;
  logic          fifo_empty;
  logic          pop;
  logic [CW-1:0] fifo_count;
  mem_tag_t      head_tag;
  logic [AW-1:0] head_idx;
  due_t          head_due;
  logic [AW-1:0] qa;
  logic [AW-1:0] ea;
  logic          cand_vld;
  mem_tag_t      cand_tag;
  logic [AW-1:0] cand_idx;
  mem_blk_t      cand_blk;

  assign qa = qry_idx[AW-1:0];
  assign ea = evict_idx[AW-1:0];

  // The answer register holds a slot until its answer cycle ends, so it counts as occupancy.
  assign ans_busy = (ans_tag != '0);
  assign accept   = (qry_cmd != MEM_CMD_NONE) && !reset &&
                    ((int'(fifo_count) + int'(ans_busy)) < NTAG);
  assign ack      = accept ? next_tag_q : '0;
  assign is_store = accept && (qry_cmd == MEM_CMD_STORE);
  assign pop      = !fifo_empty && (head_due == now_q);

  mem_pend_fifo #(.NTAG(NTAG), .IW(AW), .DUE_W(DUE_W)) u_pend (
    .clock    (clock),
    .reset    (reset),
    .push     (accept && (LATENCY > 1)),
    .push_tag (next_tag_q),
    .push_idx (qa),
    .push_due (now_q + due_t'(LATENCY - 1)),
    .pop      (pop),
    .head_tag (head_tag),
    .head_idx (head_idx),
    .head_due (head_due),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // With LATENCY=1 the query goes straight to the answer register and never enters the FIFO.
  always_comb begin
    cand_vld = pop;
    cand_tag = head_tag;
    cand_idx = head_idx;
    if (LATENCY == 1) begin
      cand_vld = accept;
      cand_tag = next_tag_q;
      cand_idx = qa;
    end
  end

  // Forward this cycle's writes so the answer reflects everything accepted before its cycle.
  always_comb begin
    cand_blk = arr_q[cand_idx];
    if (evict_valid && (ea == cand_idx)) cand_blk = evict_blk;
    if (is_store && (qa == cand_idx))    cand_blk = qry_blk;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      next_tag_q <= mem_tag_t'(1);
      now_q      <= '0;
      ans_tag    <= '0;
      ans_blk    <= '0;
      for (int i = 0; i < DEPTH; i++) arr_q[i] <= '0;
    end else begin
      now_q <= now_q + 1'b1;
      if (accept)      next_tag_q <= tag_next(next_tag_q, NTAG);
      if (evict_valid) arr_q[ea]  <= evict_blk;
      if (is_store)    arr_q[qa]  <= qry_blk;
      ans_tag <= cand_vld ? cand_tag : '0;
      ans_blk <= cand_vld ? cand_blk : '0;
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: three instances (LATENCY 4, 1 and 20), directed stimulus,
// expected answers queued at accept time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_mem_resp;
  import mem_resp_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_cmd_t qc [3];
  mem_idx_t qi [3];
  mem_blk_t qb [3];
  logic     ev [3];
  mem_idx_t ei [3];
  mem_blk_t eb [3];
  mem_tag_t ack_o [3];
  mem_tag_t at_o [3];
  mem_blk_t ab_o [3];

  mem_resp #(.DEPTH(64), .LATENCY(4), .NTAG(15)) u_l4 (
    .clock(clock), .reset(reset), .qry_cmd(qc[0]), .qry_idx(qi[0]), .qry_blk(qb[0]),
    .ack(ack_o[0]), .ans_tag(at_o[0]), .ans_blk(ab_o[0]),
    .evict_valid(ev[0]), .evict_idx(ei[0]), .evict_blk(eb[0]));

  mem_resp #(.DEPTH(64), .LATENCY(1), .NTAG(15)) u_l1 (
    .clock(clock), .reset(reset), .qry_cmd(qc[1]), .qry_idx(qi[1]), .qry_blk(qb[1]),
    .ack(ack_o[1]), .ans_tag(at_o[1]), .ans_blk(ab_o[1]),
    .evict_valid(ev[1]), .evict_idx(ei[1]), .evict_blk(eb[1]));

  mem_resp #(.DEPTH(64), .LATENCY(20), .NTAG(15)) u_l20 (
    .clock(clock), .reset(reset), .qry_cmd(qc[2]), .qry_idx(qi[2]), .qry_blk(qb[2]),
    .ack(ack_o[2]), .ans_tag(at_o[2]), .ans_blk(ab_o[2]),
    .evict_valid(ev[2]), .evict_idx(ei[2]), .evict_blk(eb[2]));

  typedef struct {
    int       dut;
    mem_tag_t tag;
    mem_blk_t blk;
    int       due;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  localparam mem_blk_t BLK_X = 64'hDEAD_BEEF_0123_4567;
  localparam mem_blk_t BLK_A = 64'hAAAA_0000_AAAA_0001;
  localparam mem_blk_t BLK_B = 64'hBBBB_0000_BBBB_0002;
  localparam mem_blk_t BLK_C = 64'hCCCC_0000_CCCC_0003;
  localparam mem_blk_t BLK_D = 64'hDDDD_0000_DDDD_0004;
  localparam mem_blk_t BLK_E = 64'hEEEE_0000_EEEE_0005;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 20;
  endfunction

  function automatic mem_blk_t vblk(input int c);
    mem_blk_t v;
    v[1] = xlen_t'(32'hC0DE_0000 + c);
    v[0] = xlen_t'(32'h1000_0000 + c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every nonzero answer must match the oldest expected entry, on its due cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        exp_t e;
        if (at_o[d] != '0) begin
          if (sbq.size() == 0) begin
            chk($sformatf("unexpected_ans_dut%0d", d), 64'(at_o[d]), 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("ans_dut", 64'(d), 64'(e.dut));
            chk("ans_tag", 64'(at_o[d]), 64'(e.tag));
            chk("ans_blk", ab_o[d], e.blk);
            chk("ans_cycle", 64'(cyc), 64'(e.due));
          end
        end else begin
          chk($sformatf("idle_blk_dut%0d", d), ab_o[d], 64'd0);
        end
      end
    end
  end

  // Drives one cycle on instance d; starts and ends just after a rising edge.
  task automatic drive(input int d, input mem_cmd_t c, input mem_idx_t i, input mem_blk_t b,
                       input logic e, input mem_idx_t ix, input mem_blk_t eblk,
                       input mem_tag_t exp_ack, input mem_blk_t exp_blk);
    qc[d] = c; qi[d] = i; qb[d] = b;
    ev[d] = e; ei[d] = ix; eb[d] = eblk;
    @(negedge clock);
    chk($sformatf("ack_dut%0d", d), 64'(ack_o[d]), 64'(exp_ack));
    if (exp_ack != '0) sbq.push_back('{d, exp_ack, exp_blk, cyc + lat_of(d)});
    @(posedge clock); #1;
    qc[d] = MEM_CMD_NONE;
    ev[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sbq.size() != 0 && k < 80) begin
      @(posedge clock); #1;
      k++;
    end
    chk(name, 64'(sbq.size()), 64'd0);
    idle(2);
  endtask

  // A LOAD is held on instance 0 throughout reset: it must never be acked.
  task automatic do_reset(input int n);
    reset = 1'b1;
    sbq.delete();
    qc[0] = MEM_CMD_LOAD;
    qi[0] = 29'd10;
    repeat (n) begin
      @(negedge clock);
      chk("ack_in_reset", 64'(ack_o[0]), 64'd0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    qc[0] = MEM_CMD_NONE;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      qc[d] = MEM_CMD_NONE; qi[d] = '0; qb[d] = '0;
      ev[d] = 1'b0; ei[d] = '0; eb[d] = '0;
    end
    do_reset(3);
    mon_en = 1'b1;

    // Single LOAD after reset: tag 1, zero data, answered exactly 4 cycles later.
    drive(0, MEM_CMD_LOAD, 29'd5, '0, 1'b0, '0, '0, 4'd1, '0);
    drain("t1_drain");

    // STORE then LOAD of the same block: both answers carry the stored data.
    do_reset(1);
    drive(0, MEM_CMD_STORE, 29'd3, BLK_X, 1'b0, '0, '0, 4'd1, BLK_X);
    drive(0, MEM_CMD_LOAD,  29'd3, '0,    1'b0, '0, '0, 4'd2, BLK_X);
    drain("t2_drain");

    // Evict/STORE collision (STORE wins), lone evict, and LOAD racing an evict.
    do_reset(1);
    drive(0, MEM_CMD_STORE, 29'd7, BLK_B, 1'b1, 29'd7, BLK_A, 4'd1, BLK_B);
    drive(0, MEM_CMD_LOAD,  29'd7, '0,    1'b0, '0,    '0,    4'd2, BLK_B);
    drive(0, MEM_CMD_NONE,  '0,    '0,    1'b1, 29'd8, BLK_C, 4'd0, '0);
    drive(0, MEM_CMD_LOAD,  29'd8, '0,    1'b0, '0,    '0,    4'd3, BLK_C);
    drive(0, MEM_CMD_LOAD,  29'd9, '0,    1'b1, 29'd9, BLK_D, 4'd4, BLK_D);
    drain("t4_drain");

    // Reset with three queries in flight: none answered, tags restart, array cleared.
    do_reset(1);
    drive(0, MEM_CMD_STORE, 29'd10, BLK_E, 1'b0, '0, '0, 4'd1, BLK_E);
    drive(0, MEM_CMD_LOAD,  29'd10, '0,    1'b0, '0, '0, 4'd2, BLK_E);
    drive(0, MEM_CMD_LOAD,  29'd10, '0,    1'b0, '0, '0, 4'd3, BLK_E);
    do_reset(1);
    idle(8);
    drive(0, MEM_CMD_LOAD, 29'd10, '0, 1'b0, '0, '0, 4'd1, '0);
    drain("t5_drain");

    // LATENCY=20: fills at 15, rejects until the first answer, then resumes with tag 1.
    do_reset(1);
    for (int c = 0; c < 30; c++) begin
      mem_tag_t ea;
      ea = (c < 15) ? mem_tag_t'(c + 1) : (c < 21) ? 4'd0 : mem_tag_t'(c - 20);
      drive(2, MEM_CMD_LOAD, mem_idx_t'(c), '0, 1'b0, '0, '0, ea, '0);
    end
    drain("t3_drain");

    // LATENCY=1: alternating STORE/LOAD, each answered on the next cycle.
    do_reset(1);
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 0)
        drive(1, MEM_CMD_STORE, mem_idx_t'(20 + c), vblk(c), 1'b0, '0, '0,
              mem_tag_t'(c + 1), vblk(c));
      else
        drive(1, MEM_CMD_LOAD, mem_idx_t'(19 + c), '0, 1'b0, '0, '0,
              mem_tag_t'(c + 1), vblk(c - 1));
    end
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
